// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: bubble encoding,
// default reset PC, FSM state encoding and the sequential-address helper.
package if_fetch_stage_pkg;

    // sll $0,$0,0 encodes as all zeros
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // FETCH: normal operation; DROP: waiting out a fetch made stale by a redirect
    typedef enum logic {
        FETCH = 1'b0,
        DROP  = 1'b1
    } fetch_state_e;

    // Sequential fetch address, 32-bit modulo; low bits pass through untouched
    function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_stage_fetch_hold_buf.sv
// One-entry skid buffer holding an instruction word and its fetch address.
// It catches a memory ack that lands while the pipeline is stalled so the
// word is neither lost nor fetched twice. Clear wins over load.
module fetch_hold_buf
    import if_fetch_stage_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] word_in,
    input  logic [31:0] addr_in,
    output logic        valid,
    output logic [31:0] word,
    output logic [31:0] addr
);

    logic        valid_reg;
    logic [31:0] word_reg;
    logic [31:0] addr_reg;

    // Capture word/address on load, drop them on clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_reg <= 1'b0;
            word_reg  <= NOP_INST_DEFAULT;
            addr_reg  <= RESET_PC_DEFAULT;
        end else if (clear) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
            word_reg  <= word_in;
            addr_reg  <= addr_in;
        end
    end

    assign valid = valid_reg;
    assign word  = word_reg;
    assign addr  = addr_reg;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage feeding the IF/ID register. Drives a req/ack
// instruction-memory port with wait states, honours hazard stalls, and
// flushes on branch/jump, discarding any fetch a redirect has made stale.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        PCWrite,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Inst,
    output logic [31:0] PcPlusFour,
    output logic        InstValid
);

    fetch_state_e state_reg, state_next;
    logic [31:0]  req_addr_reg, req_addr_next;
    logic [31:0]  pend_addr_reg, pend_addr_next;
    logic [31:0]  inst_reg, inst_next;
    logic [31:0]  ppf_reg, ppf_next;
    logic         valid_reg, valid_next;

    logic         hold_valid;
    logic [31:0]  hold_word;
    logic [31:0]  hold_addr;
    logic         hold_load;
    logic         hold_clear;

    logic         redir;
    logic [31:0]  redir_target;
    logic         ack;
    logic         word_avail;
    logic [31:0]  word;
    logic [31:0]  word_addr;

    // Branch has priority over jump when both fire
    assign redir        = BranchTaken | Jump;
    assign redir_target = BranchTaken ? BranchTarget : JumpTarget;

    // Memory port straight from registers; a stalled hold entry blocks new requests
    assign imem_req  = !reset && ((state_reg == DROP) || !hold_valid);
    assign imem_addr = req_addr_reg;

    // An ack outside a request is illegal; ignore it rather than trust it
    assign ack = imem_ack && imem_req;

    // The held word is older than anything on the bus, so it is used first
    assign word_avail = hold_valid || ack;
    assign word       = hold_valid ? hold_word : imem_rdata;
    assign word_addr  = hold_valid ? hold_addr : req_addr_reg;

    fetch_hold_buf u_hold_buf (
        .clock   (clock),
        .reset   (reset),
        .load    (hold_load),
        .clear   (hold_clear),
        .word_in (imem_rdata),
        .addr_in (req_addr_reg),
        .valid   (hold_valid),
        .word    (hold_word),
        .addr    (hold_addr)
    );

    // Next-state and next-output selection for the FETCH/DROP controller
    always_comb begin
        state_next     = state_reg;
        req_addr_next  = req_addr_reg;
        pend_addr_next = pend_addr_reg;
        inst_next      = inst_reg;
        ppf_next       = ppf_reg;
        valid_next     = valid_reg;
        hold_load      = 1'b0;
        hold_clear     = 1'b0;

        case (state_reg)
            FETCH: begin
                if (redir) begin
                    // Flush: bubble out even when stalled
                    inst_next  = NOP_INST;
                    valid_next = 1'b0;
                    hold_clear = 1'b1;
                    if (ack || !imem_req) begin
                        req_addr_next = redir_target;
                    end else begin
                        // A fetch is in flight at the old address; wait it out
                        pend_addr_next = redir_target;
                        state_next     = DROP;
                    end
                end else if (PCWrite && word_avail) begin
                    inst_next     = word;
                    ppf_next      = next_word_addr(word_addr);
                    valid_next    = 1'b1;
                    req_addr_next = next_word_addr(word_addr);
                    hold_clear    = hold_valid;
                end else if (PCWrite) begin
                    // Wait state: bubble, PcPlusFour keeps its last value
                    inst_next  = NOP_INST;
                    valid_next = 1'b0;
                end else if (ack) begin
                    // Stalled with data arriving: park it
                    hold_load = 1'b1;
                end
            end
            DROP: begin
                inst_next  = NOP_INST;
                valid_next = 1'b0;
                if (redir) begin
                    pend_addr_next = redir_target;
                end
                if (ack) begin
                    // Stale data is discarded; newest redirect target wins
                    req_addr_next = redir ? redir_target : pend_addr_reg;
                    state_next    = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // Controller state and IF/ID output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= FETCH;
            req_addr_reg  <= RESET_PC;
            pend_addr_reg <= RESET_PC;
            inst_reg      <= 32'h0000_0000;
            ppf_reg       <= 32'h0000_0000;
            valid_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            req_addr_reg  <= req_addr_next;
            pend_addr_reg <= pend_addr_next;
            inst_reg      <= inst_next;
            ppf_reg       <= ppf_next;
            valid_reg     <= valid_next;
        end
    end

    assign Inst       = inst_reg;
    assign PcPlusFour = ppf_reg;
    assign InstValid  = valid_reg;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a scoreboard of expected
// Inst/PcPlusFour pairs, pushed when a deliverable ack is driven.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clock;
    logic        reset;
    logic        PCWrite;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Inst;
    logic [31:0] PcPlusFour;
    logic        InstValid;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] ppf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    if_fetch_stage dut (
        .clock        (clock),
        .reset        (reset),
        .PCWrite      (PCWrite),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .Jump         (Jump),
        .JumpTarget   (JumpTarget),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .Inst         (Inst),
        .PcPlusFour   (PcPlusFour),
        .InstValid    (InstValid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] ppf);
        exp_t e;
        e.inst = inst;
        e.ppf  = ppf;
        sb.push_back(e);
    endtask

    // One clock: drive inputs, cross the edge, sample 1 time unit later
    task automatic step(input logic pcw, input logic br, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt,
                        input logic ack, input logic [31:0] rd);
        logic [31:0] s_inst;
        logic [31:0] s_ppf;
        logic        s_v;
        exp_t        e;
        if (ack) check("ack_legal", {31'b0, imem_req}, 32'd1);
        PCWrite      = pcw;
        BranchTaken  = br;
        BranchTarget = bt;
        Jump         = j;
        JumpTarget   = jt;
        imem_ack     = ack;
        imem_rdata   = rd;
        s_inst = Inst;
        s_ppf  = PcPlusFour;
        s_v    = InstValid;
        @(posedge clock);
        #1;
        imem_ack    = 1'b0;
        BranchTaken = 1'b0;
        Jump        = 1'b0;
        if (!pcw && !br && !j) begin
            check("stall_inst", Inst, s_inst);
            check("stall_ppf", PcPlusFour, s_ppf);
            check("stall_valid", {31'b0, InstValid}, {31'b0, s_v});
        end else if (InstValid) begin
            if (sb.size() == 0) begin
                check("sb_unexpected", {31'b0, InstValid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("inst", Inst, e.inst);
                check("ppf", PcPlusFour, e.ppf);
                $display("xfer inst=%h ppf=%h", Inst, PcPlusFour);
            end
        end
        if (!InstValid) check("bubble_nop", Inst, NOP);
    endtask

    localparam logic [31:0] Z = 32'h0;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    initial begin
        reset = 1'b1;
        PCWrite = 1'b0; BranchTaken = 1'b0; BranchTarget = Z;
        Jump = 1'b0; JumpTarget = Z; imem_ack = 1'b0; imem_rdata = Z;
        repeat (2) @(posedge clock);
        #1;
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_inst", Inst, 32'h0);
        check("rst_ppf", PcPlusFour, 32'h0);
        check("rst_valid", {31'b0, InstValid}, 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_req", {31'b0, imem_req}, 32'd1);
        check("post_rst_addr", imem_addr, 32'h0);

        // Back-to-back fetches with zero wait states
        push(32'h2000_0000, 32'h4); step(1, 0, Z, 0, Z, 1, 32'h2000_0000);
        push(32'h2000_0004, 32'h8); step(1, 0, Z, 0, Z, 1, 32'h2000_0004);
        push(32'h2000_0008, 32'hC); step(1, 0, Z, 0, Z, 1, 32'h2000_0008);
        check("addr_c", imem_addr, 32'hC);

        // Three wait states, then the word
        step(1, 0, Z, 0, Z, 0, Z);
        check("ppf_hold_bubble", PcPlusFour, 32'hC);
        check("valid_bubble", {31'b0, InstValid}, 32'd0);
        step(1, 0, Z, 0, Z, 0, Z);
        step(1, 0, Z, 0, Z, 0, Z);
        push(32'h8C22_0004, 32'h10); step(1, 0, Z, 0, Z, 1, 32'h8C22_0004);
        check("addr_10", imem_addr, 32'h10);

        // Ack during a stall parks in the hold buffer
        step(0, 0, Z, 0, Z, 1, 32'h2000_0010);
        check("stall_req_low", {31'b0, imem_req}, 32'd0);
        step(0, 0, Z, 0, Z, 0, Z);
        check("stall_req_low2", {31'b0, imem_req}, 32'd0);
        push(32'h2000_0010, 32'h14); step(1, 0, Z, 0, Z, 0, Z);
        check("addr_14", imem_addr, 32'h14);
        check("req_after_hold", {31'b0, imem_req}, 32'd1);

        // Branch with a fetch in flight: stale ack discarded
        step(1, 1, 32'h40, 0, Z, 0, Z);
        check("drop_req", {31'b0, imem_req}, 32'd1);
        check("drop_addr_stale", imem_addr, 32'h14);
        step(1, 0, Z, 0, Z, 0, Z);
        step(1, 0, Z, 0, Z, 1, JUNK);
        check("addr_40", imem_addr, 32'h40);
        push(32'h2000_0040, 32'h44); step(1, 0, Z, 0, Z, 1, 32'h2000_0040);

        // Branch beats jump
        step(1, 1, 32'h80, 1, 32'h100, 0, Z);
        step(1, 0, Z, 0, Z, 1, JUNK);
        check("addr_80", imem_addr, 32'h80);
        push(32'h2000_0080, 32'h84); step(1, 0, Z, 0, Z, 1, 32'h2000_0080);

        // Last redirect in DROP wins
        step(1, 0, Z, 1, 32'h200, 0, Z);
        step(0, 0, Z, 1, 32'h300, 0, Z);
        step(1, 0, Z, 0, Z, 1, JUNK);
        check("addr_300", imem_addr, 32'h300);
        push(32'h2000_0300, 32'h304); step(1, 0, Z, 0, Z, 1, 32'h2000_0300);

        // Redirect coinciding with the ack that ends DROP
        step(1, 1, 32'h500, 0, Z, 0, Z);
        step(1, 1, 32'h600, 0, Z, 1, JUNK);
        check("addr_600", imem_addr, 32'h600);
        push(32'h2000_0600, 32'h604); step(1, 0, Z, 0, Z, 1, 32'h2000_0600);

        // Redirect in FETCH with an ack in the same cycle
        step(1, 0, Z, 1, 32'h700, 1, JUNK);
        check("addr_700", imem_addr, 32'h700);

        // Redirect during a stall with a parked word: flush, no request lost
        step(0, 0, Z, 0, Z, 1, 32'h2000_0700);
        step(0, 1, 32'h800, 0, Z, 0, Z);
        check("flush_stall_valid", {31'b0, InstValid}, 32'd0);
        check("addr_800", imem_addr, 32'h800);
        check("req_800", {31'b0, imem_req}, 32'd1);
        push(32'h2000_0800, 32'h804); step(1, 0, Z, 0, Z, 1, 32'h2000_0800);

        // Address wrap
        step(1, 0, Z, 1, 32'hFFFF_FFFC, 0, Z);
        step(1, 0, Z, 0, Z, 1, JUNK);
        check("addr_fffc", imem_addr, 32'hFFFF_FFFC);
        push(32'hFFFF_FFFC, 32'h0); step(1, 0, Z, 0, Z, 1, 32'hFFFF_FFFC);
        check("addr_wrap", imem_addr, 32'h0);

        // Unaligned target passes through
        step(1, 0, Z, 1, 32'h102, 1, JUNK);
        push(32'h2000_0102, 32'h106); step(1, 0, Z, 0, Z, 1, 32'h2000_0102);
        check("addr_106", imem_addr, 32'h106);

        // Reset while in DROP
        step(1, 1, 32'h900, 0, Z, 0, Z);
        reset = 1'b1;
        #1;
        check("rst2_req", {31'b0, imem_req}, 32'd0);
        check("rst2_inst", Inst, 32'h0);
        check("rst2_ppf", PcPlusFour, 32'h0);
        check("rst2_valid", {31'b0, InstValid}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("rst2_rel_req", {31'b0, imem_req}, 32'd1);
        check("rst2_rel_addr", imem_addr, 32'h0);
        push(32'h2000_0000, 32'h4); step(1, 0, Z, 0, Z, 1, 32'h2000_0000);
        push(32'h2000_0004, 32'h8); step(1, 0, Z, 0, Z, 1, 32'h2000_0004);

        check("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
